// File: rtl/seg_scan_decoder.sv
// Debounces a multiplexed 7-segment scan, decodes each digit to BCD and publishes 4-digit frames.
// Build option: define SEG_ACTIVE_LOW_EN for common-anode boards (inputs inverted at the sample stage).
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  SEG_DATA,
    input  logic [3:0]  DIGIT_SEL,
    input  logic        FRAME_ACK,
    output logic [15:0] BCD_OUT,
    output logic [3:0]  DOT_OUT,
    output logic [3:0]  ERR_OUT,
    output logic        FRAME_VALID,
    output logic        OVERRUN
);

    // state  | meaning
    // IDLE   | sampled select is not one-hot
    // SETTLE | counting consecutive identical samples of a one-hot select
    // HOLD   | digit captured, waiting for the sample to change
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_seg_s, r_seg_p;
    logic [3:0]  r_sel_s, r_sel_p;
    logic [15:0] r_buf_bcd;
    logic [3:0]  r_buf_dot, r_buf_err, r_mask;
    logic [15:0] r_bcd;
    logic [3:0]  r_dot, r_err;
    logic        r_valid, r_ovr;

    logic [7:0]  w_seg_in;
    logic [3:0]  w_sel_in;
    logic        w_changed, w_onehot, w_capture, w_publish, w_err;
    logic [3:0]  w_cap_bit, w_bcd;

`ifdef SEG_ACTIVE_LOW_EN
    assign w_seg_in = ~SEG_DATA;
    assign w_sel_in = ~DIGIT_SEL;
`else
    assign w_seg_in = SEG_DATA;
    assign w_sel_in = DIGIT_SEL;
`endif

    assign w_changed = (r_seg_s != r_seg_p) || (r_sel_s != r_sel_p);
    assign w_onehot  = (r_sel_s != 4'd0) && ((r_sel_s & (r_sel_s - 4'd1)) == 4'd0);
    assign w_capture = (r_state == SETTLE) && !w_changed && ((r_cnt + 8'd1) == C_STABLE);
    assign w_cap_bit = w_capture ? r_sel_s : 4'd0;
    assign w_publish = (r_mask == 4'hF);

    always_comb begin
        w_bcd = 4'hF;
        w_err = 1'b0;
        case (r_seg_s[7:1])
            7'b1111110: w_bcd = 4'd0;
            7'b0110000: w_bcd = 4'd1;
            7'b1101101: w_bcd = 4'd2;
            7'b1111001: w_bcd = 4'd3;
            7'b0110011: w_bcd = 4'd4;
            7'b1011011: w_bcd = 4'd5;
            7'b1011111: w_bcd = 4'd6;
            7'b1110000: w_bcd = 4'd7;
            7'b1111111: w_bcd = 4'd8;
            7'b1111011: w_bcd = 4'd9;
            7'b0000000: w_bcd = 4'hF;
            default:    w_err = 1'b1;
        endcase
    end

    // The previous sample is kept so stability is judged on registered data only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_seg_s <= 8'd0;
            r_seg_p <= 8'd0;
            r_sel_s <= 4'd0;
            r_sel_p <= 4'd0;
        end else begin
            r_seg_p <= r_seg_s;
            r_sel_p <= r_sel_s;
            r_seg_s <= w_seg_in;
            r_sel_s <= w_sel_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_onehot) begin
                        r_cnt   <= 8'd1;
                        r_state <= SETTLE;
                    end
                end
                SETTLE, HOLD: begin
                    if (w_changed) begin
                        r_cnt   <= 8'd1;
                        r_state <= w_onehot ? SETTLE : IDLE;
                    end else if (r_state == SETTLE) begin
                        r_cnt <= r_cnt + 8'd1;
                        if ((r_cnt + 8'd1) == C_STABLE) r_state <= HOLD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A capture landing on the publish cycle starts the next frame's mask.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_buf_bcd <= 16'hFFFF;
            r_buf_dot <= 4'd0;
            r_buf_err <= 4'd0;
            r_mask    <= 4'd0;
            r_bcd     <= 16'hFFFF;
            r_dot     <= 4'd0;
            r_err     <= 4'd0;
            r_valid   <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_mask <= (w_publish ? 4'd0 : r_mask) | w_cap_bit;
            for (int i = 0; i < 4; i++) begin
                if (w_cap_bit[i]) begin
                    r_buf_bcd[4*i +: 4] <= w_bcd;
                    r_buf_dot[i]        <= r_seg_s[0];
                    r_buf_err[i]        <= w_err;
                end
            end
            if (w_publish) begin
                r_bcd   <= r_buf_bcd;
                r_dot   <= r_buf_dot;
                r_err   <= r_buf_err;
                r_valid <= 1'b1;
                if (r_valid) r_ovr <= !FRAME_ACK;
            end else if (r_valid && FRAME_ACK) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign BCD_OUT     = r_bcd;
    assign DOT_OUT     = r_dot;
    assign ERR_OUT     = r_err;
    assign FRAME_VALID = r_valid;
    assign OVERRUN     = r_ovr;

endmodule
